stream_wr_burst: RTL and testbench
==================================

# stream_wr_burst

Upstream write-side feeder for `mem_burst`. It accepts a valid/ready stream of `MEM_DATA_BITS`-wide words and buffers them in an internal show-ahead FIFO. It issues fixed-length write bursts (`wr_burst_req`/`len`/`addr`) into a circular frame region of DDR4 and serves `wr_burst_data_req` from the FIFO head. It replaces `mem_test` on the write path when real data (camera/DMA) must be stored.

## Interface
Parameters:
- `MEM_DATA_BITS`, 128: stream and burst data width (= `APP_DATA_WIDTH`).
- `ADDR_BITS`, 28: burst address width.
- `BURST_LEN`, 64: words per full burst, 1..512.
- `ADDR_STEP`, 8: address increment per word (`nCK_PER_CLK`×2 beats).
- `BASE_ADDR`, 0: frame region start.
- `FRAME_WORDS`, 256: region size in words, a multiple of `BURST_LEN`.
- `FIFO_DEPTH`, 128: power of two, ≥ 2×`BURST_LEN`.

Ports:
- `mem_clk` in 1: single clock (`ui_clk`).
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `init_calib_complete` in 1: no burst is started while low.
- `s_data` in `MEM_DATA_BITS`: stream word.
- `s_valid` in 1 / `s_ready` out 1: stream handshake.
- `frame_start` in 1: pulse, restart address at `BASE_ADDR`.
- `flush` in 1: level, drain a partial burst.
- `wr_burst_req` out 1: burst request, level.
- `wr_burst_len` out 10: words in the current burst.
- `wr_burst_addr` out `ADDR_BITS`: burst start address.
- `wr_burst_data_req` in 1: `mem_burst` consumes `wr_burst_data` this cycle.
- `wr_burst_data` out `MEM_DATA_BITS`: FIFO head word, combinational.
- `wr_burst_finish` in 1: one-cycle pulse, burst done.
- `underflow` out 1: sticky; data requested while the FIFO was empty.
- `burst_cnt` out 16: completed bursts, wraps at 2^16.

## Operation
- Push: `s_valid & s_ready`. `s_ready = !full`, derived from registered state, so a same-cycle pop does not raise it.
- Pop: `wr_burst_data_req`.
- The FIFO is show-ahead: `wr_burst_data` equals the head word whenever the FIFO is non-empty, and 0 when empty.
- FSM states: IDLE, REQ.
- IDLE → REQ when `init_calib_complete` and either:
  - `count ≥ BURST_LEN`: latch `wr_burst_len = BURST_LEN`; or
  - `flush` and `0 < count < BURST_LEN`: latch `wr_burst_len = count`.
- `wr_burst_addr` is latched from the address pointer on the same transition.
- REQ: hold `wr_burst_req = 1` and keep len/addr stable until `wr_burst_finish`; then → IDLE.
- On finish, pointer += `wr_burst_len`×`ADDR_STEP`. If the result is ≥ `BASE_ADDR + FRAME_WORDS×ADDR_STEP`, the pointer becomes `BASE_ADDR` (wrap).
- `burst_cnt` increments on each finish.
- Address arithmetic is modulo 2^`ADDR_BITS`. Length fits in 10 bits.
- `frame_start` in IDLE: pointer ← `BASE_ADDR` immediately. In REQ: set a pending flag and apply the reset at finish, overriding the increment.
- A `frame_start` that coincides with the IDLE→REQ transition uses the old pointer for that burst, and the reset applies at its finish.
- `wr_burst_data_req` while empty: `underflow` ← 1 (cleared only by reset), no pop.
- Words pushed during a burst are valid for the same burst.

## Timing
- Reset (async, `rst_n` low) clears:
  - FIFO pointers/count, so `s_ready` = 1 after release.
  - FSM → IDLE.
  - `wr_burst_req`, `wr_burst_len`, `wr_burst_addr`, `underflow`, `burst_cnt` = 0.
  - Pointer = `BASE_ADDR`; pending flag = 0.
- Reset mid-burst abandons the burst; `mem_burst` is reset by the same domain.
- Latency: the condition is evaluated on registered count. `wr_burst_req` rises one cycle after the push that makes `count = BURST_LEN`.
- After `wr_burst_finish`, `wr_burst_req` is low the next cycle. The earliest re-assert is the cycle after that.
- Full: `s_ready` low while `count = FIFO_DEPTH`. It rises the cycle after a pop.

## Structure
- Package `mem_pkg`: the FSM state enum, `BURST_LEN_W = 10`, and shared defaults for `MEM_DATA_BITS`/`ADDR_BITS`.
- Sub-module `sync_fifo_fwft`: single-clock show-ahead FIFO with count, full and empty outputs, parameterised width and depth.
- FSM, address pointer and counters live in `stream_wr_burst`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream → all outputs 0, `s_ready` = 1 after release, first burst at addr 0.
- **Full burst:** push 64 words, calib = 1 → `wr_burst_req` one cycle later with len 64, addr 0. Model 64 data_reqs, then finish → `burst_cnt` = 1, next addr 512. Data order matches input.
- **Wrap:** push 320 words → bursts at addr 0, 512, 1024, 1536, then 0.
- **Flush:** push 10 words, assert `flush` → burst len 10. Next pointer advances by 80.
- **Gating/backpressure:** calib = 0 and push until `s_ready` = 0 at count 128 → no request issued. Set calib = 1 → request fires. `s_ready` returns 1 the cycle after the first pop.
- **Mid-burst `frame_start` and underflow:** pulse `frame_start` during the burst at addr 512 → next burst at 0. Issue a data_req with an empty FIFO → `underflow` = 1 and stays 1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the DDR write-path feeder blocks.
package mem_pkg;

   localparam int MEM_DATA_BITS_DEF = 128;
   localparam int ADDR_BITS_DEF     = 28;
   localparam int BURST_LEN_W       = 10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } wr_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO: the head word is visible on rd_data whenever
// the FIFO holds data, and rd_data reads as zero when it is empty.
module sync_fifo_fwft #(
   parameter int   WIDTH = 128,
   parameter int   DEPTH = 128,
   localparam int  CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   // Full/empty come from the registered count, so a pop never frees a slot
   // for a push in the same cycle.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage array, written on accepted pushes only.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Read/write pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/stream_wr_burst.sv
// Stream-to-burst write feeder: buffers incoming words and issues fixed-length
// write bursts into a circular DDR frame region, serving burst data from the
// FIFO head.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no burst outstanding; waiting for calibration and enough data
// ST_REQ  | wr_burst_req held with stable len/addr until wr_burst_finish
module stream_wr_burst
   import mem_pkg::*;
#(
   parameter int MEM_DATA_BITS = MEM_DATA_BITS_DEF,
   parameter int ADDR_BITS     = ADDR_BITS_DEF,
   parameter int BURST_LEN     = 64,
   parameter int ADDR_STEP     = 8,
   parameter int BASE_ADDR     = 0,
   parameter int FRAME_WORDS   = 256,
   parameter int FIFO_DEPTH    = 128
) (
   input  logic                     mem_clk,
   input  logic                     rst_n,
   input  logic                     init_calib_complete,
   input  logic [MEM_DATA_BITS-1:0] s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic                     frame_start,
   input  logic                     flush,
   output logic                     wr_burst_req,
   output logic [BURST_LEN_W-1:0]   wr_burst_len,
   output logic [ADDR_BITS-1:0]     wr_burst_addr,
   input  logic                     wr_burst_data_req,
   output logic [MEM_DATA_BITS-1:0] wr_burst_data,
   input  logic                     wr_burst_finish,
   output logic                     underflow,
   output logic [15:0]              burst_cnt
);

   localparam int                   CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(BURST_LEN);
   localparam logic [ADDR_BITS-1:0] BASE      = ADDR_BITS'(BASE_ADDR);
   localparam logic [ADDR_BITS-1:0] FRAME_END = ADDR_BITS'(BASE_ADDR + FRAME_WORDS * ADDR_STEP);

   wr_state_e              state_q;
   wr_state_e              state_d;
   logic                   start_burst;
   logic [BURST_LEN_W-1:0] start_len;

   logic [CNT_W-1:0]       fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;

   logic [ADDR_BITS-1:0]   ptr_q;
   logic [ADDR_BITS-1:0]   ptr_step;
   logic [ADDR_BITS-1:0]   ptr_next;
   logic                   pending_q;
   logic [BURST_LEN_W-1:0] len_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [15:0]            burst_cnt_q;
   logic                   underflow_q;

   assign s_ready = !fifo_full;

   sync_fifo_fwft #(
      .WIDTH (MEM_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (mem_clk),
      .rst_n   (rst_n),
      .wr_en   (s_valid),
      .wr_data (s_data),
      .rd_en   (wr_burst_data_req),
      .rd_data (wr_burst_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Pointer after the current burst, wrapped back to the region start.
   assign ptr_step = ptr_q + (ADDR_BITS'(len_q) * ADDR_BITS'(ADDR_STEP));
   assign ptr_next = (ptr_step >= FRAME_END) ? BASE : ptr_step;

   // Next-state: start a full burst when enough data is buffered, or drain a
   // partial one on flush; both wait for calibration.
   always_comb begin
      state_d     = state_q;
      start_burst = 1'b0;
      start_len   = '0;
      case (state_q)
         ST_IDLE: begin
            if (init_calib_complete) begin
               if (fifo_count >= FULL_CNT) begin
                  start_burst = 1'b1;
                  start_len   = BURST_LEN_W'(BURST_LEN);
               end else if (flush && (fifo_count != '0)) begin
                  start_burst = 1'b1;
                  start_len   = BURST_LEN_W'(fifo_count);
               end
            end
            if (start_burst) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (wr_burst_finish) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Burst descriptor, frame pointer with deferred frame_start, and counters.
   // A frame_start landing on the launch edge is deferred so the launching
   // burst keeps the old address.
   always_ff @(posedge mem_clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q       <= '0;
         addr_q      <= '0;
         ptr_q       <= BASE;
         pending_q   <= 1'b0;
         burst_cnt_q <= '0;
         underflow_q <= 1'b0;
      end else begin
         if (start_burst) begin
            len_q     <= start_len;
            addr_q    <= ptr_q;
            pending_q <= frame_start;
         end else if ((state_q == ST_IDLE) && frame_start) begin
            ptr_q <= BASE;
         end
         if (state_q == ST_REQ) begin
            if (wr_burst_finish) begin
               ptr_q       <= (pending_q || frame_start) ? BASE : ptr_next;
               pending_q   <= 1'b0;
               burst_cnt_q <= burst_cnt_q + 16'd1;
            end else if (frame_start) begin
               pending_q <= 1'b1;
            end
         end
         if (wr_burst_data_req && fifo_empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign wr_burst_req  = (state_q == ST_REQ);
   assign wr_burst_len  = len_q;
   assign wr_burst_addr = addr_q;
   assign burst_cnt     = burst_cnt_q;
   assign underflow     = underflow_q;

endmodule

// File: tb/tb_stream_wr_burst.sv
// Directed-sequence bench with random payloads for stream_wr_burst, checked
// against a queue-based model of the buffered data and the frame pointer.
module tb_stream_wr_burst;

   localparam int DW          = 128;
   localparam int AW          = 28;
   localparam int BURST_LEN   = 64;
   localparam int ADDR_STEP   = 8;
   localparam int BASE_ADDR   = 0;
   localparam int FRAME_WORDS = 256;
   localparam int FIFO_DEPTH  = 128;

   logic          mem_clk = 1'b0;
   logic          rst_n;
   logic          init_calib_complete;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          frame_start;
   logic          flush;
   logic          wr_burst_req;
   logic [9:0]    wr_burst_len;
   logic [AW-1:0] wr_burst_addr;
   logic          wr_burst_data_req;
   logic [DW-1:0] wr_burst_data;
   logic          wr_burst_finish;
   logic          underflow;
   logic [15:0]   burst_cnt;

   stream_wr_burst #(
      .MEM_DATA_BITS (DW),
      .ADDR_BITS     (AW),
      .BURST_LEN     (BURST_LEN),
      .ADDR_STEP     (ADDR_STEP),
      .BASE_ADDR     (BASE_ADDR),
      .FRAME_WORDS   (FRAME_WORDS),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) dut (
      .mem_clk             (mem_clk),
      .rst_n               (rst_n),
      .init_calib_complete (init_calib_complete),
      .s_data              (s_data),
      .s_valid             (s_valid),
      .s_ready             (s_ready),
      .frame_start         (frame_start),
      .flush               (flush),
      .wr_burst_req        (wr_burst_req),
      .wr_burst_len        (wr_burst_len),
      .wr_burst_addr       (wr_burst_addr),
      .wr_burst_data_req   (wr_burst_data_req),
      .wr_burst_data       (wr_burst_data),
      .wr_burst_finish     (wr_burst_finish),
      .underflow           (underflow),
      .burst_cnt           (burst_cnt)
   );

   always #5 mem_clk = ~mem_clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   logic [DW-1:0] mq[$];
   longint        mptr;
   int            mcnt;
   bit            mpend;
   int            mlen;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge mem_clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push_words(input int n);
      int done  = 0;
      int guard = 0;
      while (done < n && guard < 2000) begin
         s_data  = rnd_word();
         s_valid = 1'b1;
         if (s_ready) begin
            mq.push_back(s_data);
            done++;
         end
         step();
         guard++;
      end
      s_valid = 1'b0;
      if (done < n) check("push_timeout", DW'(done), DW'(n));
   endtask

   task automatic wait_req();
      int guard = 0;
      while (!wr_burst_req && guard < 300) begin
         step();
         guard++;
      end
      check("req_seen", DW'(wr_burst_req), DW'(1));
   endtask

   task automatic check_hdr(input int exp_len);
      mlen = exp_len;
      check("burst_len", DW'(wr_burst_len), DW'(exp_len));
      check("burst_addr", DW'(wr_burst_addr), DW'(mptr));
   endtask

   task automatic pop_words(input int n);
      logic [DW-1:0] exp;
      for (int i = 0; i < n; i++) begin
         exp = (mq.size() > 0) ? mq.pop_front() : '0;
         wr_burst_data_req = 1'b1;
         check("burst_data", wr_burst_data, exp);
         step();
      end
      wr_burst_data_req = 1'b0;
   endtask

   task automatic finish_burst();
      longint nxt;
      wr_burst_finish = 1'b1;
      step();
      wr_burst_finish = 1'b0;
      check("req_drop", DW'(wr_burst_req), DW'(0));
      nxt = mptr + longint'(mlen) * ADDR_STEP;
      if (mpend) mptr = BASE_ADDR;
      else if (nxt >= BASE_ADDR + FRAME_WORDS * ADDR_STEP) mptr = BASE_ADDR;
      else mptr = nxt;
      mpend = 1'b0;
      mcnt++;
      check("burst_cnt", DW'(burst_cnt), DW'(mcnt & 16'hffff));
   endtask

   task automatic full_burst();
      wait_req();
      check_hdr(BURST_LEN);
      pop_words(BURST_LEN);
      finish_burst();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      init_calib_complete = 1'b0;
      s_data = '0;
      s_valid = 1'b0;
      frame_start = 1'b0;
      flush = 1'b0;
      wr_burst_data_req = 1'b0;
      wr_burst_finish = 1'b0;
      mptr = BASE_ADDR;
      mcnt = 0;
      mpend = 1'b0;
      mlen = 0;

      // Power-on reset
      repeat (3) step();
      check("rst_req", DW'(wr_burst_req), DW'(0));
      check("rst_len", DW'(wr_burst_len), DW'(0));
      check("rst_addr", DW'(wr_burst_addr), DW'(0));
      check("rst_underflow", DW'(underflow), DW'(0));
      check("rst_burst_cnt", DW'(burst_cnt), DW'(0));
      rst_n = 1'b1;
      step();
      check("rst_s_ready", DW'(s_ready), DW'(1));

      // Reset mid-stream discards buffered data
      push_words(20);
      check("pre_rst_data", wr_burst_data, mq[0]);
      rst_n = 1'b0;
      #1;
      check("midrst_data", wr_burst_data, '0);
      check("midrst_req", DW'(wr_burst_req), DW'(0));
      mq.delete();
      #2;
      rst_n = 1'b1;
      step();
      check("midrst_s_ready", DW'(s_ready), DW'(1));

      // Full burst with request latency
      init_calib_complete = 1'b1;
      push_words(BURST_LEN);
      check("lat_req_low", DW'(wr_burst_req), DW'(0));
      step();
      check("lat_req_high", DW'(wr_burst_req), DW'(1));
      check_hdr(BURST_LEN);
      pop_words(BURST_LEN);
      finish_burst();
      check("empty_data_zero", wr_burst_data, '0);

      // Frame restart in idle, then wrap across the region
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      mptr = BASE_ADDR;
      for (int b = 0; b < 5; b++) begin
         push_words(BURST_LEN);
         full_burst();
      end

      // Partial data waits for flush
      push_words(10);
      repeat (4) step();
      check("partial_no_req", DW'(wr_burst_req), DW'(0));
      flush = 1'b1;
      wait_req();
      flush = 1'b0;
      check_hdr(10);
      pop_words(10);
      finish_burst();

      // Calibration gating and backpressure at full
      init_calib_complete = 1'b0;
      push_words(FIFO_DEPTH);
      check("full_s_ready", DW'(s_ready), DW'(0));
      s_valid = 1'b1;
      s_data = rnd_word();
      step();
      s_valid = 1'b0;
      repeat (3) step();
      check("gated_no_req", DW'(wr_burst_req), DW'(0));
      init_calib_complete = 1'b1;
      wait_req();
      check_hdr(BURST_LEN);
      wr_burst_data_req = 1'b1;
      check("first_pop_data", wr_burst_data, mq.pop_front());
      check("ready_before_pop", DW'(s_ready), DW'(0));
      step();
      wr_burst_data_req = 1'b0;
      check("ready_after_pop", DW'(s_ready), DW'(1));
      pop_words(BURST_LEN - 1);
      finish_burst();
      full_burst();

      // Mid-burst frame_start defers the restart to the finish
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      mptr = BASE_ADDR;
      push_words(BURST_LEN);
      full_burst();
      push_words(BURST_LEN);
      wait_req();
      check_hdr(BURST_LEN);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      mpend = 1'b1;
      pop_words(BURST_LEN);
      finish_burst();

      // frame_start on the launch edge: burst keeps old pointer, restart at finish
      push_words(BURST_LEN);
      push_words(BURST_LEN);
      full_burst();
      frame_start = 1'b1;
      wait_req();
      frame_start = 1'b0;
      mpend = 1'b1;
      check_hdr(BURST_LEN);
      pop_words(BURST_LEN);
      finish_burst();
      push_words(10);
      flush = 1'b1;
      wait_req();
      flush = 1'b0;
      check_hdr(10);
      pop_words(10);
      finish_burst();

      // Underflow on an empty request is sticky
      check("no_underflow_yet", DW'(underflow), DW'(0));
      wr_burst_data_req = 1'b1;
      check("underflow_data", wr_burst_data, '0);
      step();
      wr_burst_data_req = 1'b0;
      check("underflow_set", DW'(underflow), DW'(1));
      repeat (5) step();
      check("underflow_sticky", DW'(underflow), DW'(1));
      check("final_req", DW'(wr_burst_req), DW'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
